// File: rtl/dm_arbiter.sv
// dm_arbiter
// Single-port data-memory arbiter between the pipeline MEM stage and an
// external loader/debug port. Owns the DM address/data/write-enable mux and
// freezes the pipeline while a loader burst holds the memory and the MEM
// stage needs it. A starvation counter forces the loader in after
// STARVE_LIMIT consecutive denied cycles.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata MEM-stage access request, store flag, address, data
//   cpu_rdata, cpu_stall  load data to MEM/WB; pipeline freeze
//   ld_req/we/addr/len    loader burst request (held until ld_done),
//                         direction, base address, beats minus one
//   ld_wdata, ld_rdata    per-beat write / read data
//   ld_gnt, ld_beat       loader owns DM; a beat executes this cycle
//   ld_done               one-cycle pulse after the final beat
//   dm_we/addr/wdata      data-memory write enable, address, write data
//   dm_rdata              data-memory combinational read data
module dm_arbiter #(
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int LENW         = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_stall,
  input  logic            ld_req,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [LENW-1:0] ld_len,
  input  logic [DW-1:0]   ld_wdata,
  output logic            ld_gnt,
  output logic            ld_beat,
  output logic [DW-1:0]   ld_rdata,
  output logic            ld_done,
  output logic            dm_we,
  output logic [AW-1:0]   dm_addr,
  output logic [DW-1:0]   dm_wdata,
  input  logic [DW-1:0]   dm_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_CPU,
    ST_BURST,
    ST_DONE
  } state_t;

  state_t          state, next_state;
  logic [SW-1:0]   starve;
  logic [LENW-1:0] beat;
  logic [LENW-1:0] lat_len;
  logic [AW-1:0]   lat_addr;
  logic            lat_we;
  logic            starved;
  logic            grant;

  assign starved = (starve == SW'(STARVE_LIMIT));
  // The loader wins when the MEM stage is idle, or when it has waited long
  // enough. A forced grant still lets this cycle's CPU access complete.
  assign grant   = (state == ST_CPU) && ld_req && (!cpu_req || starved);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_CPU;
    else     state <= next_state;
  end

  // Burst bookkeeping and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve   <= '0;
      beat     <= '0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_len  <= '0;
    end else begin
      case (state)
        ST_CPU: begin
          if (grant) begin
            lat_we   <= ld_we;
            lat_addr <= ld_addr;
            lat_len  <= ld_len;
            beat     <= '0;
            starve   <= '0;
          end else if (!ld_req) begin
            starve <= '0;
          end else if (!starved) begin
            // Loader denied because the MEM stage holds the memory.
            starve <= starve + 1'b1;
          end
        end
        ST_BURST: beat <= beat + 1'b1;
        default:  ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_CPU:   if (grant) next_state = ST_BURST;
      ST_BURST: if (beat == lat_len) next_state = ST_DONE;
      ST_DONE:  next_state = ST_CPU;
      default:  next_state = ST_CPU;
    endcase
  end

  // Output and memory mux.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    dm_we     = cpu_we;
    dm_addr   = cpu_addr;
    dm_wdata  = cpu_wdata;
    cpu_stall = 1'b0;
    ld_gnt    = 1'b0;
    ld_beat   = 1'b0;
    ld_done   = 1'b0;
    case (state)
      ST_BURST: begin
        dm_we     = lat_we;
        // Burst addresses wrap modulo the DM depth.
        dm_addr   = lat_addr + AW'(beat);
        dm_wdata  = ld_wdata;
        cpu_stall = cpu_req;
        ld_gnt    = 1'b1;
        ld_beat   = 1'b1;
      end
      ST_DONE:  ld_done = 1'b1;
      default:  ;
    endcase
    // Block any write on the reset cycle, including one in mid-burst.
    if (rst) dm_we = 1'b0;
  end

  assign cpu_rdata = dm_rdata;
  assign ld_rdata  = dm_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model that
// keeps the pending burst as a queue of addresses and a reference memory.
module tb_dm_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [2:0]  ld_len = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_gnt, ld_beat, ld_done;
  logic [31:0] ld_rdata;
  logic        dm_we;
  logic [4:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_len(ld_len),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_beat(ld_beat),
    .ld_rdata(ld_rdata), .ld_done(ld_done),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] mem [32];
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

  // Stimulus staged here and applied to the DUT only at the falling edge.
  typedef struct {
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        ld_req;
    logic        ld_we;
    logic [4:0]  ld_addr;
    logic [2:0]  ld_len;
    logic [31:0] ld_wdata;
  } stim_t;
  stim_t s;

  // Behavioural model.
  logic [31:0] ref_mem [32];
  int          beat_q[$];   // addresses of burst beats still to execute
  logic        m_we;        // direction of the running burst
  logic        m_done;      // the cycle after the last beat
  int          starve;
  logic        e_done;      // expected ld_done of the last tick

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: apply stimulus, compare every output against the model,
  // then advance the model across the coming rising edge.
  task automatic tick();
    logic        in_burst, e_we, e_stall, e_gnt;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    @(negedge clk);
    rst = s.rst; cpu_req = s.cpu_req; cpu_we = s.cpu_we; cpu_addr = s.cpu_addr;
    cpu_wdata = s.cpu_wdata; ld_req = s.ld_req; ld_we = s.ld_we;
    ld_addr = s.ld_addr; ld_len = s.ld_len; ld_wdata = s.ld_wdata;
    #2;
    in_burst = (beat_q.size() > 0);
    if (in_burst) begin
      e_addr = 5'(beat_q[0]); e_we = m_we; e_wdata = s.ld_wdata;
      e_stall = s.cpu_req; e_gnt = 1'b1; e_done = 1'b0;
    end else begin
      e_addr = s.cpu_addr; e_we = s.cpu_we; e_wdata = s.cpu_wdata;
      e_stall = 1'b0; e_gnt = 1'b0; e_done = m_done;
    end
    if (s.rst) e_we = 1'b0;

    check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    check("ld_gnt",    32'(ld_gnt),    32'(e_gnt));
    check("ld_beat",   32'(ld_beat),   32'(e_gnt));
    check("ld_done",   32'(ld_done),   32'(e_done));
    check("dm_we",     32'(dm_we),     32'(e_we));
    check("dm_addr",   32'(dm_addr),   32'(e_addr));
    check("dm_wdata",  dm_wdata,       e_wdata);
    if (in_burst) check("ld_rdata", ld_rdata, ref_mem[e_addr]);
    else if (s.cpu_req) check("cpu_rdata", cpu_rdata, ref_mem[e_addr]);

    if (e_we) ref_mem[e_addr] = e_wdata;
    if (s.rst) begin
      beat_q.delete(); m_done = 1'b0; starve = 0;
    end else if (in_burst) begin
      void'(beat_q.pop_front());
      if (beat_q.size() == 0) m_done = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (s.ld_req && (!s.cpu_req || starve == LIMIT)) begin
      for (int i = 0; i <= int'(s.ld_len); i++) beat_q.push_back((int'(s.ld_addr) + i) % 32);
      m_we = s.ld_we; starve = 0;
    end else if (s.ld_req) begin
      starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    end else begin
      starve = 0;
    end
  endtask

  task automatic new_burst();
    s.ld_we   = 1'($urandom);
    s.ld_addr = 5'($urandom);
    s.ld_len  = 3'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   wrap_addr[4];
    logic [31:0] exp_rst [6];
    logic pend;
    wrap_addr = '{30, 31, 0, 1};
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 32'hC0DE_0000 + 32'(i);
      ref_mem[i] = 32'hC0DE_0000 + 32'(i);
    end
    m_we = 1'b0; m_done = 1'b0; starve = 0; e_done = 1'b0;
    s = '{default: '0};
    s.rst = 1'b1;
    tick(); tick();

    // Reset state.
    s.rst = 1'b0;
    tick();
    check("rst_stall", 32'(cpu_stall), 0);
    check("rst_gnt",   32'(ld_gnt),    0);
    check("rst_beat",  32'(ld_beat),   0);
    check("rst_done",  32'(ld_done),   0);

    // Idle loader: store then load.
    s.cpu_req = 1'b1; s.cpu_we = 1'b1; s.cpu_addr = 5'd3; s.cpu_wdata = 32'hDEAD_BEEF;
    tick();
    check("store_we",   32'(dm_we),   1);
    check("store_addr", 32'(dm_addr), 3);
    s.cpu_we = 1'b0;
    tick();
    check("load_data",  cpu_rdata, 32'hDEAD_BEEF);
    check("load_stall", 32'(cpu_stall), 0);
    s.cpu_req = 1'b0;
    tick();

    // Loader write burst with address wrap.
    s.ld_req = 1'b1; s.ld_we = 1'b1; s.ld_addr = 5'd30; s.ld_len = 3'd3;
    tick();
    check("wrap_grant_cycle", 32'(ld_gnt), 0);
    for (int i = 0; i < 4; i++) begin
      s.ld_wdata = 32'hA000_0000 + 32'(i);
      tick();
      check("wrap_gnt",  32'(ld_gnt),  1);
      check("wrap_addr", 32'(dm_addr), 32'(wrap_addr[i]));
      check("wrap_we",   32'(dm_we),   1);
    end
    s.ld_req = 1'b0;
    tick();
    check("wrap_done", 32'(ld_done), 1);
    check("wrap_gnt_off", 32'(ld_gnt), 0);
    for (int i = 0; i < 4; i++) begin
      s.cpu_req = 1'b1; s.cpu_we = 1'b0; s.cpu_addr = 5'(wrap_addr[i]);
      tick();
      check("wrap_readback", cpu_rdata, 32'hA000_0000 + 32'(i));
    end
    s.cpu_req = 1'b0;
    tick();

    // MEM load arrives at beat 1 of a read burst.
    s.ld_req = 1'b1; s.ld_we = 1'b0; s.ld_addr = 5'd10; s.ld_len = 3'd3;
    tick();
    tick();
    check("rb_beat0_stall", 32'(cpu_stall), 0);
    check("rb_beat0_rdata", ld_rdata, 32'hC0DE_000A);
    s.cpu_req = 1'b1; s.cpu_we = 1'b0; s.cpu_addr = 5'd3;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("rb_stall", 32'(cpu_stall), 1);
    end
    s.ld_req = 1'b0;
    tick();
    check("rb_done_stall", 32'(cpu_stall), 0);
    check("rb_done",       32'(ld_done),   1);
    check("rb_done_rdata", cpu_rdata, 32'hDEAD_BEEF);
    s.cpu_req = 1'b0;
    tick();

    // Starvation: grant on the fifth request edge.
    s.cpu_req = 1'b1; s.cpu_we = 1'b0; s.cpu_addr = 5'd3;
    s.ld_req = 1'b1; s.ld_we = 1'b1; s.ld_addr = 5'd5; s.ld_len = 3'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("starve_wait", 32'(ld_gnt), 0);
    end
    s.cpu_we = 1'b1; s.cpu_addr = 5'd7; s.cpu_wdata = 32'h1234_5678;
    tick();
    check("starve_cpu_gnt",  32'(ld_gnt),  0);
    check("starve_cpu_we",   32'(dm_we),   1);
    check("starve_cpu_addr", 32'(dm_addr), 7);
    s.cpu_we = 1'b0; s.ld_wdata = 32'h55;
    tick();
    check("starve_gnt",   32'(ld_gnt),    1);
    check("starve_stall", 32'(cpu_stall), 1);
    check("starve_addr0", 32'(dm_addr),   5);
    s.ld_wdata = 32'h66;
    tick();
    check("starve_addr1", 32'(dm_addr), 6);
    s.ld_req = 1'b0;
    tick();
    check("starve_commit", cpu_rdata, 32'h1234_5678);
    s.cpu_req = 1'b0;
    tick();

    // Reset at beat 2 of a 6-beat write burst.
    s.ld_req = 1'b1; s.ld_we = 1'b1; s.ld_addr = 5'd20; s.ld_len = 3'd5;
    tick();
    s.ld_wdata = 32'hB0; tick();
    s.ld_wdata = 32'hB1; tick();
    s.ld_wdata = 32'hB2; s.rst = 1'b1;
    tick();
    check("rst_burst_we", 32'(dm_we), 0);
    s.rst = 1'b0; s.ld_req = 1'b0;
    exp_rst = '{32'hB0, 32'hB1, 32'hC0DE_0016, 32'hC0DE_0017, 32'hC0DE_0018, 32'hC0DE_0019};
    for (int i = 0; i < 6; i++) begin
      s.cpu_req = 1'b1; s.cpu_we = 1'b0; s.cpu_addr = 5'(20 + i);
      tick();
      if (i == 0) begin
        check("rst_burst_gnt",   32'(ld_gnt),    0);
        check("rst_burst_stall", 32'(cpu_stall), 0);
      end
      check("rst_burst_mem", cpu_rdata, exp_rst[i]);
    end
    s.cpu_req = 1'b0;
    tick();

    // Back-to-back bursts with ld_req held high.
    s.ld_req = 1'b1; s.ld_we = 1'b1; s.ld_addr = 5'd2; s.ld_len = 3'd1;
    tick();
    tick(); tick();
    tick();
    check("b2b_done",     32'(ld_done), 1);
    check("b2b_done_gnt", 32'(ld_gnt),  0);
    tick();
    check("b2b_cpu_gnt", 32'(ld_gnt), 0);
    tick();
    check("b2b_regrant", 32'(ld_gnt), 1);
    tick();
    s.ld_req = 1'b0;
    tick();
    tick();

    // Randomized traffic.
    pend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      s.rst = ($urandom_range(0, 199) == 0);
      if (s.rst) pend = 1'b0;
      else if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        new_burst();
      end
      s.ld_req    = pend;
      s.cpu_req   = ($urandom_range(0, 9) < 8);
      s.cpu_we    = 1'($urandom);
      s.cpu_addr  = 5'($urandom);
      s.cpu_wdata = $urandom;
      s.ld_wdata  = $urandom;
      tick();
      if (e_done) begin
        pend = 1'($urandom);
        if (pend) new_burst();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
